// File: rtl/img_rx_pkg.sv
// Shared types and constants for the UART image-frame receiver.
package img_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HI    = 2'd1,
        S_LO    = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_TRAILER = 2'b10;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h5A;

endpackage

// File: rtl/uart_img_framer_timeout.sv
// Inter-byte idle watchdog: counts cycles without a byte while enabled.
module rx_timeout_cnt #(
    parameter int TIMEOUT_CYC = 104_166
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_kick,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!i_enable || i_kick) begin
            cnt_d = '0;
        end
    end

    // Fires on the cycle the count would reach TIMEOUT_CYC; a byte that cycle wins.
    assign o_expired = i_enable && !i_kick && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_img_framer.sv
// Frame receiver: header detect, byte-pair pixel packing, raster tracking,
// trailer check and timeout abort. All outputs are registered.
module uart_img_framer
    import img_rx_pkg::*;
#(
    parameter int          IMG_W       = 100,
    parameter int          IMG_H       = 80,
    parameter int          PIX_W       = 12,
    parameter int          ADDR_W      = 15,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int          TIMEOUT_CYC = 104_166
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_ram_wre,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [PIX_W-1:0]  o_ram_din,
    output logic [11:0]       o_xpos,
    output logic [11:0]       o_ypos,
    output logic [ADDR_W-1:0] o_pixcnt,
    output logic              o_receiving,
    output logic              o_complete,
    output logic              o_frame_done,
    output logic [1:0]        o_error,
    output state_t            o_dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [11:0]       LAST_COL = 12'(IMG_W - 1);

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [11:0]         col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0]   pixcnt_q, pixcnt_d, addr_q, addr_d;
    logic [PIX_W-1:0]    din_q, din_d;
    logic [11:0]         xpos_q, xpos_d, ypos_q, ypos_d;
    logic                wre_q, wre_d, recv_q, recv_d;
    logic                complete_q, complete_d, done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic                expired;

    rx_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .i_enable  (state_q != S_IDLE),
        .i_kick    (i_rx_valid),
        .o_expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        col_d      = col_q;
        row_d      = row_q;
        pixcnt_d   = pixcnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        wre_d      = 1'b0;
        recv_d     = recv_q;
        complete_d = complete_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
                state_d    = S_HI;
                pixcnt_d   = '0;
                col_d      = '0;
                row_d      = '0;
                xpos_d     = '0;
                ypos_d     = '0;
                complete_d = 1'b0;
                err_d      = ERR_NONE;
                recv_d     = 1'b1;
            end
            S_HI: if (i_rx_valid) begin
                hi_d    = i_rx_data;
                state_d = S_LO;
            end
            S_LO: if (i_rx_valid) begin
                // Narrow pixels keep the top bits of the low byte.
                wre_d    = 1'b1;
                addr_d   = pixcnt_q;
                din_d    = {hi_q, i_rx_data[7 -: PIX_W-8]};
                xpos_d   = col_q;
                ypos_d   = row_q;
                pixcnt_d = pixcnt_q + 1'b1;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                state_d = (pixcnt_q == LAST_PIX) ? S_TRAIL : S_HI;
            end
            S_TRAIL: if (i_rx_valid) begin
                state_d = S_IDLE;
                recv_d  = 1'b0;
                if (i_rx_data == SYNC_BYTE) begin
                    complete_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    err_d = ERR_TRAILER;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (expired) begin
            state_d = S_IDLE;
            recv_d  = 1'b0;
            err_d   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pixcnt_q   <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            wre_q      <= 1'b0;
            recv_q     <= 1'b0;
            complete_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pixcnt_q   <= pixcnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            wre_q      <= wre_d;
            recv_q     <= recv_d;
            complete_q <= complete_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_ram_wre    = wre_q;
    assign o_ram_addr   = addr_q;
    assign o_ram_din    = din_q;
    assign o_xpos       = xpos_q;
    assign o_ypos       = ypos_q;
    assign o_pixcnt     = pixcnt_q;
    assign o_receiving  = recv_q;
    assign o_complete   = complete_q;
    assign o_frame_done = done_q;
    assign o_error      = err_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_uart_img_framer.sv
// Randomised bench for uart_img_framer: a 12-bit and a 16-bit instance share one
// byte stream and are compared every cycle against a frame-level reference model.
module tb_uart_img_framer;
    import img_rx_pkg::*;

    localparam int         IMG_W = 4;
    localparam int         IMG_H = 2;
    localparam int         NPIX  = IMG_W * IMG_H;
    localparam int         TO    = 64;
    localparam logic [7:0] SYNC  = 8'h5A;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    always #5 clk = ~clk;

    logic        wre12, recv12, comp12, done12;
    logic [14:0] addr12, pc12;
    logic [11:0] din12, x12, y12;
    logic [1:0]  err12;
    state_t      st12;
    logic        wre16, recv16, comp16, done16;
    logic [14:0] addr16, pc16;
    logic [15:0] din16;
    logic [11:0] x16, y16;
    logic [1:0]  err16;
    state_t      st16;

    uart_img_framer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(12), .ADDR_W(15),
                      .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)) dut12 (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_ram_wre(wre12), .o_ram_addr(addr12), .o_ram_din(din12),
        .o_xpos(x12), .o_ypos(y12), .o_pixcnt(pc12), .o_receiving(recv12),
        .o_complete(comp12), .o_frame_done(done12), .o_error(err12), .o_dbg_state(st12));

    uart_img_framer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(16), .ADDR_W(15),
                      .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)) dut16 (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_ram_wre(wre16), .o_ram_addr(addr16), .o_ram_din(din16),
        .o_xpos(x16), .o_ypos(y16), .o_pixcnt(pc16), .o_receiving(recv16),
        .o_complete(comp16), .o_frame_done(done16), .o_error(err16), .o_dbg_state(st16));

    // reference model: frame position is the byte index after the header
    bit          m_in_frame, m_complete, m_wre, m_done;
    int          m_idx, m_idle, m_err, m_pixcnt, m_addr, m_x, m_y;
    logic [7:0]  m_hi;
    logic [11:0] m_din12;
    logic [15:0] m_din16;
    logic [30:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_complete = 0; m_wre = 0; m_done = 0;
        m_idx = 0; m_idle = 0; m_err = 0; m_pixcnt = 0; m_addr = 0; m_x = 0; m_y = 0;
        m_hi = 8'h00; m_din12 = '0; m_din16 = '0;
        exp_q.delete();
    endtask

    task automatic model_update(input logic v, input logic [7:0] d);
        int p;
        m_wre = 0;
        m_done = 0;
        if (!m_in_frame) begin
            if (v && d == SYNC) begin
                m_in_frame = 1; m_idx = 0; m_idle = 0; m_complete = 0; m_err = 0;
                m_pixcnt = 0; m_x = 0; m_y = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_idx < 2 * NPIX) begin
                if (m_idx % 2 == 0) begin
                    m_hi = d;
                end else begin
                    p = m_idx / 2;
                    m_wre = 1; m_addr = p; m_x = p % IMG_W; m_y = p / IMG_W;
                    m_din12 = {m_hi, d[7:4]};
                    m_din16 = {m_hi, d};
                    m_pixcnt = p + 1;
                    exp_q.push_back({15'(p), m_din16});
                end
                m_idx++;
            end else begin
                m_in_frame = 0;
                if (d == SYNC) begin
                    m_complete = 1;
                    m_done = 1;
                end else begin
                    m_err = 2;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_in_frame = 0;
                m_err = 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [30:0] e;
        check("wre12", wre12, m_wre);
        check("done12", done12, m_done);
        check("recv12", recv12, m_in_frame);
        check("complete12", comp12, m_complete);
        check("error12", err12, m_err);
        check("pixcnt12", pc12, m_pixcnt);
        check("addr12", addr12, m_addr);
        check("din12", din12, m_din12);
        check("xpos12", x12, m_x);
        check("ypos12", y12, m_y);
        check("idle_state12", st12 == S_IDLE, !m_in_frame);
        check("wre16", wre16, m_wre);
        check("recv16", recv16, m_in_frame);
        check("error16", err16, m_err);
        check("complete16", comp16, m_complete);
        if (wre16) begin
            if (exp_q.size() == 0) begin
                check("wr16_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr16_addr", addr16, e[30:16]);
                check("wr16_din", din16, e[15:0]);
            end
        end
    endtask

    // driver tasks
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_update(v, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_pixels(input int n, input logic [7:0] hi, input logic [7:0] lo);
        for (int i = 0; i < n; i++) begin
            send(hi);
            send(lo);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_wre", wre12, 0);
        check("rst_addr", addr12, 0);
        check("rst_din", din12, 0);
        check("rst_xy", {x12, y12}, 0);
        check("rst_pixcnt", pc12, 0);
        check("rst_flags", {recv12, comp12, done12, err12}, 0);
        check("rst_state", st12, S_IDLE);
        check("rst_dut16", {wre16, addr16, din16, recv16, comp16, err16}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_frame();
        int gap;
        logic [7:0] b;
        for (int i = $urandom_range(0, 3); i > 0; i--) send(8'($urandom_range(0, 255)));
        send(SYNC);
        for (int i = 0; i < 2 * NPIX + 1; i++) begin
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 68) : $urandom_range(0, 2);
            idle(gap);
            if (i == 2 * NPIX)
                b = ($urandom_range(0, 3) != 0) ? SYNC : 8'($urandom_range(0, 255));
            else
                b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
            send(b);
        end
        idle($urandom_range(0, 3));
    endtask

    initial begin
        #2;
        do_reset();

        // nominal frame and back-to-back 16-bit pattern
        send(SYNC); send_pixels(NPIX, 8'hAB, 8'hC0); send(SYNC);
        idle(2);
        send(SYNC); send_pixels(NPIX, 8'h12, 8'h34); send(SYNC);

        // marker byte as pixel data
        send(SYNC); send(SYNC); send(8'h5F); send_pixels(NPIX - 1, 8'h11, 8'h22); send(SYNC);

        // bad trailer, then restart
        send(SYNC); send_pixels(NPIX, 8'h3C, 8'h96); send(8'h00);
        idle(3);
        send(SYNC); send_pixels(NPIX, 8'h77, 8'h88); send(SYNC);

        // timeout after 3 pixels; then a byte exactly on the last allowed idle cycle
        send(SYNC); send_pixels(3, 8'hE1, 8'hF2); idle(70);
        send(SYNC); send_pixels(1, 8'h01, 8'h02); idle(TO - 1); send(8'h03);
        idle(TO - 1); send(8'h04); send_pixels(NPIX - 2, 8'h05, 8'h06); send(SYNC);

        // reset mid-frame, junk ignored, fresh frame
        send(SYNC); send_pixels(2, 8'hAA, 8'h55);
        do_reset();
        send(8'h00); idle(2);
        send(SYNC); send_pixels(NPIX, 8'hC3, 8'h3C); send(SYNC);

        for (int f = 0; f < 40; f++) random_frame();
        idle(TO + 2);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
